// File: rtl/bnn_inst_fetch.sv
// Instruction fetch stage for the BPU controller.
// Owns the PC, drives the instruction SRAM read port and buffers fetched words
// in a small prefetch FIFO.
//
// Handshakes:
//   inst/inst_valid/inst_ready : a word transfers on any cycle where
//     inst_valid && inst_ready. inst_valid never depends on inst_ready.
//   isram_en/isram_rdata : a read issued with isram_en returns on isram_rdata
//     exactly one cycle later.
//   redir_valid : single-cycle pulse. It flushes the FIFO, moves the PC and
//     toggles the epoch so that any read still in flight is dropped on return.
module bnn_inst_fetch #(
  parameter int ADDR_W     = 16,
  parameter int INST_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              isram_en,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [INST_W-1:0] isram_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STOP  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [INST_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                inflight;
  logic                inflight_epoch;
  logic                epoch;

  logic                empty;
  logic [CNT_W-1:0]    credit;
  logic [INST_W-1:0]   head;
  logic                head_halt;
  logic                rdata_halt;
  logic                pop;
  logic                push;
  logic                redir_take;
  logic                halt_pop;

  // Credit counts the in-flight read, so a full FIFO can never be overrun.
  always_comb begin
    empty      = (count == '0);
    credit     = count + CNT_W'(inflight);
    head       = mem[rd_ptr];
    head_halt  = (head[INST_W-1 -: 5] == 5'b11111);
    rdata_halt = (isram_rdata[INST_W-1 -: 5] == 5'b11111);
    redir_take = redir_valid && (state != S_IDLE);
    isram_en   = (state == S_FETCH) && !redir_valid && (credit < CNT_W'(FIFO_DEPTH));
    isram_addr = pc;
    inst_valid = !empty;
    inst       = empty ? '0 : head;
    pop        = inst_valid && inst_ready;
    push       = inflight && (inflight_epoch == epoch) && (state == S_FETCH) && !redir_take;
    halt_pop   = pop && head_halt && (state == S_STOP) && !redir_take;
    done       = halt_pop;
    busy       = (state != S_IDLE);
  end

  // FIFO storage; only written on an accepted return.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= isram_rdata;
  end

  // Control FSM: PC, FIFO pointers, in-flight tracking and epoch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pc             <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight       <= isram_en;
      inflight_epoch <= epoch;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= start_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_FETCH;
          end
        end
        default: begin
          if (redir_take) begin
            // A pop in this cycle already completed; the flush discards the rest.
            epoch  <= ~epoch;
            pc     <= redir_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_FETCH;
          end else begin
            if (isram_en) pc <= pc + ADDR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push && rdata_halt) state <= S_STOP;
            if (halt_pop)           state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Bench for bnn_inst_fetch: per-cycle vector table for a linear program, then
// hand-written sequences for backpressure, redirects, PC wrap and async reset.
module tb_bnn_inst_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] start_pc;
  logic        isram_en;
  logic [15:0] isram_addr;
  logic [15:0] isram_rdata;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int gaps   = 0;

  logic [15:0] sram [0:65535];
  logic [15:0] exp_q [$];

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        exp_en;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_inst;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [10];

  bnn_inst_fetch #(.ADDR_W(16), .INST_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .isram_en(isram_en), .isram_addr(isram_addr), .isram_rdata(isram_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .busy(busy), .done(done)
  );

  // Clock and synchronous-read SRAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial isram_rdata = '0;
  always @(posedge clk) begin
    if (isram_en) isram_rdata <= sram[isram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    32'(isram_en),   32'h0);
    check({tag, "_addr"},  32'(isram_addr), 32'h0);
    check({tag, "_inst"},  32'(inst),       32'h0);
    check({tag, "_valid"}, 32'(inst_valid), 32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
    check({tag, "_done"},  32'(done),       32'h0);
  endtask

  // Scoreboard: every pop must match exp_q in order; ends when done is seen.
  task automatic drain(input string tag, input int max_cycles);
    bit done_seen = 0;
    bit popped_once = 0;
    gaps = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        popped_once = 1;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_pop"}, 32'(inst), 32'hFFFFFFFF);
        end else begin
          check({tag, "_pop"}, 32'(inst), 32'(exp_q.pop_front()));
        end
      end else if (popped_once && !done_seen) begin
        gaps++;
      end
      if (done) done_seen = 1;
      step();
      redir_valid = 1'b0;
      start = 1'b0;
      if (done_seen) break;
    end
    check({tag, "_done_seen"}, 32'(done_seen), 32'h1);
    check({tag, "_queue_empty"}, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int en_cnt;
    for (int a = 0; a < 65536; a++) sram[a] = 16'h0000;
    sram[0] = 16'h0801; sram[1] = 16'h2001; sram[2] = 16'h2801;
    sram[3] = 16'h3805; sram[4] = 16'h3800; sram[5] = 16'hF800;
    sram[16'h0010] = 16'h5555; sram[16'h0011] = 16'hF800;
    sram[16'h0020] = 16'h3001; sram[16'h0021] = 16'h1111;
    sram[16'h0022] = 16'h2222; sram[16'h0023] = 16'h3333;
    sram[16'h0030] = 16'h4444; sram[16'h0031] = 16'hF800;

    //            start ready en   addr      valid inst      done busy
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0801, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h2001, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h2801, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h3805, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h3800, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF800, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset
    rst = 1'b1; start = 1'b0; start_pc = '0; inst_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = '0;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    step(); step();
    @(negedge clk) rst = 1'b1;
    step();

    // Linear fetch, table driven
    for (int r = 0; r < 10; r++) begin
      start = tbl[r].start; start_pc = 16'h0000; inst_ready = tbl[r].ready;
      @(negedge clk);
      check($sformatf("lin%0d_en", r),    32'(isram_en),   32'(tbl[r].exp_en));
      if (tbl[r].exp_en) check($sformatf("lin%0d_addr", r), 32'(isram_addr), 32'(tbl[r].exp_addr));
      check($sformatf("lin%0d_valid", r), 32'(inst_valid), 32'(tbl[r].exp_valid));
      check($sformatf("lin%0d_inst", r),  32'(inst),       32'(tbl[r].exp_inst));
      check($sformatf("lin%0d_done", r),  32'(done),       32'(tbl[r].exp_done));
      check($sformatf("lin%0d_busy", r),  32'(busy),       32'(tbl[r].exp_busy));
      step();
    end
    start = 1'b0;

    // Backpressure: 10 cycles with inst_ready low
    en_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0); start_pc = 16'h0000; inst_ready = 1'b0;
      @(negedge clk);
      if (isram_en) en_cnt++;
      step();
    end
    start = 1'b0;
    @(negedge clk);
    check("bp_en_count", en_cnt, 32'd4);
    check("bp_en_held", 32'(isram_en), 32'h0);
    check("bp_pc", 32'(isram_addr), 32'h0004);
    check("bp_valid", 32'(inst_valid), 32'h1);
    check("bp_head", 32'(inst), 32'h0801);
    step();
    inst_ready = 1'b1;
    exp_q = '{16'h0801, 16'h2001, 16'h2801, 16'h3805, 16'h3800, 16'hF800};
    drain("bp", 30);
    check("bp_gaps", gaps, 32'd0);

    // Redirect with 3 buffered entries and one read in flight
    inst_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); start_pc = 16'h0000;
      step();
    end
    start = 1'b0;
    redir_valid = 1'b1; redir_pc = 16'h0002;
    @(negedge clk);
    check("rd_no_en", 32'(isram_en), 32'h0);
    step();
    redir_valid = 1'b0;
    @(negedge clk);
    check("rd_first_en", 32'(isram_en), 32'h1);
    check("rd_first_addr", 32'(isram_addr), 32'h0002);
    check("rd_flushed", 32'(inst_valid), 32'h0);
    step();
    @(negedge clk);
    check("rd_still_empty", 32'(inst_valid), 32'h0);
    step();
    inst_ready = 1'b1;
    @(negedge clk);
    check("rd_valid", 32'(inst_valid), 32'h1);
    check("rd_inst", 32'(inst), 32'h2801);
    step();
    exp_q = '{16'h3805, 16'h3800, 16'hF800};
    drain("rd", 30);

    // Redirect coincident with pop of 0x3001
    inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start = (c == 0); start_pc = 16'h0020;
      step();
    end
    start = 1'b0;
    inst_ready = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0030;
    @(negedge clk);
    check("co_valid", 32'(inst_valid), 32'h1);
    check("co_inst", 32'(inst), 32'h3001);
    step();
    redir_valid = 1'b0;
    exp_q = '{16'h4444, 16'hF800};
    drain("co", 30);

    // PC wrap
    sram[16'hFFFF] = 16'h0801;
    sram[16'h0000] = 16'hF800;
    start = 1'b1; start_pc = 16'hFFFF; inst_ready = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("wrap_en0", 32'(isram_en), 32'h1);
    check("wrap_addr0", 32'(isram_addr), 32'h0000FFFF);
    step();
    @(negedge clk);
    check("wrap_en1", 32'(isram_en), 32'h1);
    check("wrap_addr1", 32'(isram_addr), 32'h00000000);
    step();
    exp_q = '{16'h0801, 16'hF800};
    drain("wrap", 20);

    // Asynchronous reset mid-fetch with 3 entries buffered
    inst_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); start_pc = 16'h0020;
      step();
    end
    start = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("arst");
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_en", c), 32'(isram_en), 32'h0);
      check($sformatf("post_rst%0d_busy", c), 32'(busy), 32'h0);
      step();
    end
    start = 1'b1; start_pc = 16'h0010; inst_ready = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("restart_en", 32'(isram_en), 32'h1);
    check("restart_addr", 32'(isram_addr), 32'h0010);
    exp_q = '{16'h5555, 16'hF800};
    drain("restart", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
